// File: rtl/jk_flip_flop_arst_if.sv
// JK flop bank signal bundle: per-bit J/K inputs and the registered state with its complement.
// The master drives j/k and observes q/q_n; the flop bank is the slave.
interface jk_flip_flop_arst_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;

    modport master (
        output j,
        output k,
        input  q,
        input  q_n
    );

    modport slave (
        input  j,
        input  k,
        output q,
        output q_n
    );
endinterface

// File: rtl/jk_flip_flop_arst.sv
// Bank of WIDTH independent rising-edge JK flops with asynchronous active-low reset.
// q_n is derived combinationally from q, so it tracks q through reset as well.
module jk_flip_flop_arst #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst,
    jk_flip_flop_arst_if.slave  jk
);

    logic [WIDTH-1:0] q_p0;

    // Characteristic equation q+ = j&~q | ~k&q covers hold, clear, set and toggle per bit.
    function automatic logic [WIDTH-1:0] jk_next(
        input logic [WIDTH-1:0] q_cur,
        input logic [WIDTH-1:0] j_in,
        input logic [WIDTH-1:0] k_in
    );
        return (j_in & ~q_cur) | (~k_in & q_cur);
    endfunction

    // Stage 0: state register; reset wins over any edge while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_p0 <= RESET_VALUE;
        end else begin
            q_p0 <= jk_next(q_p0, jk.j, jk.k);
        end
    end

    assign jk.q   = q_p0;
    assign jk.q_n = ~q_p0;

endmodule

// File: tb/tb_jk_flip_flop_arst.sv
// Self-checking bench for jk_flip_flop_arst: a 1-bit and a 4-bit instance driven by
// directed vector tables, hand-written reset sequences and randomized stimulus.
module tb_jk_flip_flop_arst;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_checks;
    int n_fail;

    jk_flip_flop_arst_if #(.WIDTH(1)) if_a ();
    jk_flip_flop_arst_if #(.WIDTH(4)) if_b ();

    jk_flip_flop_arst #(.WIDTH(1), .RESET_VALUE(1'b0)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .jk  (if_a)
    );

    jk_flip_flop_arst #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .jk  (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic j;
        logic k;
        logic exp_q;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the JK truth table applied bit by bit, masked to the instance width.
    function automatic logic [3:0] model_next(input logic [3:0] q, input logic [3:0] j,
                                              input logic [3:0] k, input int w);
        logic [3:0] n;
        n = 4'b0000;
        for (int i = 0; i < w; i++) begin
            case ({j[i], k[i]})
                2'b00:   n[i] = q[i];
                2'b01:   n[i] = 1'b0;
                2'b10:   n[i] = 1'b1;
                default: n[i] = ~q[i];
            endcase
        end
        return n;
    endfunction

    initial begin
        logic [3:0] mq_a;
        logic [3:0] mq_b;
        logic [3:0] ja;
        logic [3:0] ka;
        logic [3:0] jb;
        logic [3:0] kb;
        int         sel;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{j: 1'b0, k: 1'b0, exp_q: 1'b1};
        vecs[1] = '{j: 1'b0, k: 1'b0, exp_q: 1'b1};
        vecs[2] = '{j: 1'b0, k: 1'b1, exp_q: 1'b0};
        vecs[3] = '{j: 1'b1, k: 1'b1, exp_q: 1'b1};
        vecs[4] = '{j: 1'b1, k: 1'b1, exp_q: 1'b0};
        vecs[5] = '{j: 1'b1, k: 1'b1, exp_q: 1'b1};
        vecs[6] = '{j: 1'b1, k: 1'b1, exp_q: 1'b0};
        vecs[7] = '{j: 1'b1, k: 1'b1, exp_q: 1'b1};

        rst_a  = 1'b1;
        rst_b  = 1'b1;
        if_a.j = 1'b0;
        if_a.k = 1'b0;
        if_b.j = 4'b0000;
        if_b.k = 4'b0000;

        // Reset state, asserted before any clock edge
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("reset_a_q",   {3'b000, if_a.q},   4'b0000);
        chk("reset_a_qn",  {3'b000, if_a.q_n}, 4'b0001);
        chk("reset_b_q",   if_b.q,             4'b1010);
        chk("reset_b_qn",  if_b.q_n,           4'b0101);

        // Test 1: get q=1, then async reset between edges, then edges ignored in reset
        rst_a  = 1'b1;
        if_a.j = 1'b1;
        if_a.k = 1'b0;
        tick();
        chk("pre_set_q", {3'b000, if_a.q}, 4'b0001);
        #2;
        rst_a = 1'b0;
        #1;
        chk("async_rst_q",  {3'b000, if_a.q},   4'b0000);
        chk("async_rst_qn", {3'b000, if_a.q_n}, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_q", {3'b000, if_a.q}, 4'b0000);
        end

        // Test 2: release does not set q; the next edge does
        rst_a = 1'b1;
        #1;
        chk("release_no_set", {3'b000, if_a.q}, 4'b0000);
        tick();
        chk("release_set_q",  {3'b000, if_a.q},   4'b0001);
        chk("release_set_qn", {3'b000, if_a.q_n}, 4'b0000);

        // Tests 3 and 4: hold, clear, then five toggles
        foreach (vecs[i]) begin
            if_a.j = vecs[i].j;
            if_a.k = vecs[i].k;
            tick();
            chk($sformatf("vec%0d_q", i),  {3'b000, if_a.q},   {3'b000, vecs[i].exp_q});
            chk($sformatf("vec%0d_qn", i), {3'b000, if_a.q_n}, {3'b000, ~vecs[i].exp_q});
        end

        // Test 6: short reset pulse while toggling from q=1
        rst_a = 1'b0;
        #1;
        chk("midop_rst_q",  {3'b000, if_a.q},   4'b0000);
        chk("midop_rst_qn", {3'b000, if_a.q_n}, 4'b0001);
        #1;
        rst_a = 1'b1;
        tick();
        chk("midop_resume1", {3'b000, if_a.q}, 4'b0001);
        tick();
        chk("midop_resume2", {3'b000, if_a.q}, 4'b0000);

        // Test 5: 4-bit bank, j/k applied during reset are ignored, then one edge after release
        if_b.j = 4'b0011;
        if_b.k = 4'b0101;
        tick();
        chk("bank_rst_ignores_edge", if_b.q, 4'b1010);
        rst_b = 1'b1;
        #1;
        chk("bank_release_no_change", if_b.q, 4'b1010);
        tick();
        chk("bank_q",  if_b.q,   4'b1011);
        chk("bank_qn", if_b.q_n, 4'b0100);

        // Randomized stimulus against the truth-table model, with occasional resets
        mq_a = 4'b0000;
        mq_b = 4'b1011;
        for (int n = 0; n < 300; n++) begin
            ja  = 4'($urandom_range(0, 1));
            ka  = 4'($urandom_range(0, 1));
            jb  = 4'($urandom_range(0, 15));
            kb  = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 15);
            if_a.j = ja[0];
            if_a.k = ka[0];
            if_b.j = jb;
            if_b.k = kb;
            if (sel <= 1) begin
                rst_a = 1'b0;
                rst_b = 1'b0;
                #1;
                mq_a = 4'b0000;
                mq_b = 4'b1010;
                chk("rnd_rst_a", {3'b000, if_a.q}, mq_a);
                chk("rnd_rst_b", if_b.q, mq_b);
                if (sel == 0) begin
                    #1;
                    rst_a = 1'b1;
                    rst_b = 1'b1;
                end
            end
            tick();
            if (sel != 1) begin
                mq_a = model_next(mq_a, ja, ka, 1);
                mq_b = model_next(mq_b, jb, kb, 4);
            end
            chk("rnd_a_q",  {3'b000, if_a.q},   mq_a);
            chk("rnd_a_qn", {3'b000, if_a.q_n}, {3'b000, ~mq_a[0]});
            chk("rnd_b_q",  if_b.q,   mq_b);
            chk("rnd_b_qn", if_b.q_n, ~mq_b);
            if (sel == 1) begin
                rst_a = 1'b1;
                rst_b = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
